// File: rtl/pulse_decoder_2to4_pkg.sv
// Shared definitions for the 2-to-4 pulse decoder: state encoding, code width
// and the one-hot reference function.
package pulse_decoder_2to4_pkg;

    localparam int CODE_W = 2;
    localparam int Y_W    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Width of the hold counter: enough for PULSE_LEN-1, never narrower than one bit.
    function automatic int hcnt_width(input int pulse_len);
        int w;
        if (pulse_len > 1) begin
            w = $clog2(pulse_len);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    function automatic logic [Y_W-1:0] onehot4(input logic [CODE_W-1:0] code);
        logic [Y_W-1:0] r;
        case (code)
            2'b00:   r = 4'b0001;
            2'b01:   r = 4'b0010;
            2'b10:   r = 4'b0100;
            2'b11:   r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pulse_decoder_2to4_if.sv
// Code-in / pulse-out bundle of the 2-to-4 pulse decoder.
interface pulse_decoder_2to4_if
    import pulse_decoder_2to4_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic              en;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] code;
    logic [Y_W-1:0]    y;
    logic              y_valid;
    logic              done;
    logic              aborted;
    logic [CNT_W-1:0]  accept_cnt;

    modport master (
        output en, in_valid, code,
        input  in_ready, y, y_valid, done, aborted, accept_cnt
    );

    modport slave (
        input  en, in_valid, code,
        output in_ready, y, y_valid, done, aborted, accept_cnt
    );

endinterface

// File: rtl/pulse_decoder_2to4_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count register with saturation at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pulse_decoder_2to4.sv
// Registered 2-to-4 decoder: each accepted code drives its one-hot line for
// PULSE_LEN cycles, then reports done (or aborted if en drops mid-pulse).
module pulse_decoder_2to4
    import pulse_decoder_2to4_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pulse_decoder_2to4_if.slave  bus
);

    localparam int                HCNT_W    = hcnt_width(PULSE_LEN);
    localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(PULSE_LEN - 1);
    localparam logic [HCNT_W-1:0] HCNT_ZERO = HCNT_W'(0);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

    state_t            state_r;
    state_t            state_n;
    logic [HCNT_W-1:0] hcnt_r;
    logic [HCNT_W-1:0] hcnt_n;
    logic [Y_W-1:0]    y_r;
    logic [Y_W-1:0]    y_n;
    logic              y_valid_r;
    logic              y_valid_n;
    logic              done_r;
    logic              done_n;
    logic              aborted_r;
    logic              aborted_n;
    logic              final_cycle_s;
    logic              in_ready_s;
    logic              accept_s;

    // The final DRIVE cycle may take a new code so pulses can run back-to-back.
    assign final_cycle_s = (state_r == ST_DRIVE) && (hcnt_r == HCNT_ZERO);
    assign in_ready_s    = bus.en && ((state_r == ST_IDLE) || final_cycle_s);
    assign accept_s      = bus.in_valid && in_ready_s;

    // Next-state, hold-count and output-value decode.
    always_comb begin
        state_n   = state_r;
        hcnt_n    = hcnt_r;
        y_n       = y_r;
        y_valid_n = y_valid_r;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n   = ST_DRIVE;
                    hcnt_n    = HCNT_LOAD;
                    y_n       = onehot4(bus.code);
                    y_valid_n = 1'b1;
                end else begin
                    y_n       = 4'b0000;
                    y_valid_n = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (!bus.en) begin
                    state_n   = ST_IDLE;
                    hcnt_n    = HCNT_ZERO;
                    y_n       = 4'b0000;
                    y_valid_n = 1'b0;
                    aborted_n = 1'b1;
                end else if (hcnt_r != HCNT_ZERO) begin
                    hcnt_n = hcnt_r - HCNT_ONE;
                end else if (accept_s) begin
                    // Previous pulse finished normally; reload without a zero gap.
                    hcnt_n    = HCNT_LOAD;
                    y_n       = onehot4(bus.code);
                    y_valid_n = 1'b1;
                    done_n    = 1'b1;
                end else begin
                    state_n   = ST_IDLE;
                    y_n       = 4'b0000;
                    y_valid_n = 1'b0;
                    done_n    = 1'b1;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                hcnt_n    = HCNT_ZERO;
                y_n       = 4'b0000;
                y_valid_n = 1'b0;
            end
        endcase
    end

    // State, hold counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            hcnt_r    <= HCNT_ZERO;
            y_r       <= 4'b0000;
            y_valid_r <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            hcnt_r    <= hcnt_n;
            y_r       <= y_n;
            y_valid_r <= y_valid_n;
            done_r    <= done_n;
            aborted_r <= aborted_n;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_accept_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept_s),
        .count (bus.accept_cnt)
    );

    assign bus.in_ready = in_ready_s;
    assign bus.y        = y_r;
    assign bus.y_valid  = y_valid_r;
    assign bus.done     = done_r;
    assign bus.aborted  = aborted_r;

endmodule
